// File: rtl/lvds_prbs_checker.sv
// PRBS7 (x^7 + x^6 + 1) byte-wide checker for deserialized LVDS data.
// Hunts for alignment, confirms it over LOCK_CNT bytes, then counts bit errors.
module lvds_prbs_checker #(
    parameter int LOCK_CNT   = 16,
    parameter int UNLOCK_CNT = 4
) (
    input  logic        CLK,
    input  logic        RSTX,
    input  logic        CLR,
    input  logic        DIN_VALID,
    input  logic [7:0]  DIN,
    output logic        LOCKED,
    output logic [29:0] RECV_CNT,
    output logic [31:0] ERR_CNT,
    output logic        ERR_BYTE
);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LAST   = 8'(LOCK_CNT - 1);
    localparam logic [7:0] UNLOCK_LAST = 8'(UNLOCK_CNT - 1);

    state_t      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [7:0]  match_q, match_d;
    logic [7:0]  run_q, run_d;
    logic [29:0] recv_q, recv_d;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic        err_byte_q, err_byte_d;
    logic        locked_q;

    logic [6:0]  gen_s;
    logic        gen_b;
    logic [7:0]  exp_byte;
    logic [7:0]  diff;
    logic [3:0]  nerr;
    logic [32:0] err_sum;
    logic        seed_ok;
    logic        byte_ok;

    // lfsr[6] is the oldest bit; after 8 steps the new state is exp_byte[6:0]
    always_comb begin
        gen_s    = lfsr_q;
        gen_b    = 1'b0;
        exp_byte = '0;
        for (int i = 7; i >= 0; i--) begin
            gen_b       = gen_s[6] ^ gen_s[5];
            exp_byte[i] = gen_b;
            gen_s       = {gen_s[5:0], gen_b};
        end
    end

    always_comb begin
        diff = DIN ^ exp_byte;
        nerr = '0;
        for (int i = 0; i < 8; i++) begin
            nerr = nerr + {3'b000, diff[i]};
        end
    end

    assign seed_ok = |DIN[6:0];
    assign byte_ok = (diff == 8'h00);

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q <= HUNT;
            lfsr_q  <= '0;
            match_q <= '0;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            match_q <= match_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        match_d = match_q;
        run_d   = run_q;
        if (DIN_VALID) begin
            unique case (state_q)
                HUNT: begin
                    lfsr_d  = DIN[6:0];
                    match_d = '0;
                    if (seed_ok) begin
                        state_d = SYNC;
                    end
                end
                SYNC: begin
                    if (byte_ok) begin
                        lfsr_d  = exp_byte[6:0];
                        match_d = match_q + 8'd1;
                        if (match_q == LOCK_LAST) begin
                            state_d = LOCK;
                            run_d   = '0;
                        end
                    end else begin
                        lfsr_d  = DIN[6:0];
                        match_d = '0;
                        if (!seed_ok) begin
                            state_d = HUNT;
                        end
                    end
                end
                LOCK: begin
                    // locked tracking never reseeds from the (possibly bad) data
                    lfsr_d = exp_byte[6:0];
                    if (nerr != 4'd0) begin
                        if (run_q == UNLOCK_LAST) begin
                            state_d = HUNT;
                            run_d   = '0;
                            match_d = '0;
                        end else begin
                            run_d = run_q + 8'd1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    always_comb begin
        err_byte_d = 1'b0;
        recv_d     = recv_q;
        err_cnt_d  = err_cnt_q;
        err_sum    = {1'b0, err_cnt_q} + {29'd0, nerr};
        if (DIN_VALID && (state_q == LOCK)) begin
            err_byte_d = (nerr != 4'd0);
            if (~&recv_q) begin
                recv_d = recv_q + 30'd1;
            end
            err_cnt_d = err_sum[32] ? '1 : err_sum[31:0];
        end
        if (CLR) begin
            recv_d    = '0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            recv_q     <= '0;
            err_cnt_q  <= '0;
            err_byte_q <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            recv_q     <= recv_d;
            err_cnt_q  <= err_cnt_d;
            err_byte_q <= err_byte_d;
            locked_q   <= (state_d == LOCK);
        end
    end

    assign LOCKED   = locked_q;
    assign RECV_CNT = recv_q;
    assign ERR_CNT  = err_cnt_q;
    assign ERR_BYTE = err_byte_q;

endmodule

// File: doc/lvds_prbs_checker.md
LVDS_PRBS_CHECKER -- requirements
Module: lvds_prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 16: number of consecutive matching bytes needed to declare lock (range 1..255).
REQ-002 SHALL have parameter UNLOCK_CNT, default 4: number of consecutive errored bytes while locked that forces loss of lock (range 1..255).
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port RSTX, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port CLR, input, 1 bit: synchronous counter clear.
REQ-006 SHALL have port DIN_VALID, input, 1 bit: DIN carries one deserialized byte this cycle.
REQ-007 SHALL have port DIN, input, 8 bits: received byte; DIN[7] is earliest in time, DIN[0] is latest.
REQ-008 SHALL have port LOCKED, output, 1 bit: checker is aligned to the PRBS7 stream.
REQ-009 SHALL have port RECV_CNT, output, 30 bits: bytes checked while locked.
REQ-010 SHALL have port ERR_CNT, output, 32 bits: bit errors detected while locked.
REQ-011 SHALL have port ERR_BYTE, output, 1 bit: one-cycle pulse when a byte checked while locked has at least one bit error.

Function
REQ-012 SHALL check PRBS7 data, with b[n] = b[n-7] XOR b[n-6], serialized MSB-first within each byte.
REQ-013 SHALL use a 7-bit LFSR state holding the last 7 expected bits; the expected byte is the next 8 bits generated from that state.
REQ-014 SHALL implement three states, HUNT, SYNC and LOCK, and SHALL change state only on cycles with DIN_VALID=1.
REQ-015 In HUNT, on a valid byte: load the LFSR with DIN[6:0]; if DIN[6:0]=0, stay in HUNT (illegal seed); otherwise go to SYNC with match_cnt=0.
REQ-016 In SYNC, on a matching byte: advance the LFSR by 8 bits and increment match_cnt; when match_cnt reaches LOCK_CNT, go to LOCK.
REQ-017 In SYNC, on a mismatching byte: reseed from DIN[6:0] using the HUNT rule and clear match_cnt; go to HUNT if DIN[6:0]=0, otherwise stay in SYNC.
REQ-018 In LOCK, on each valid byte: always advance the LFSR by the expected bits (no reseed); compute err = popcount(DIN XOR expected), range 0..8.
REQ-019 In LOCK, on each valid byte: RECV_CNT += 1 and ERR_CNT += err, both registered, visible the cycle after the byte.
REQ-020 In LOCK, when err>0, ERR_BYTE SHALL pulse high for one cycle, aligned with the counter update.
REQ-021 In LOCK, a run counter SHALL increment on each errored byte and clear on each clean byte; when it reaches UNLOCK_CNT, go to HUNT.
REQ-022 On the transition to HUNT from LOCK, the byte that completes the error run SHALL still be counted.
REQ-023 LOCKED SHALL be 1 exactly while the state is LOCK, as a registered output.
REQ-024 RECV_CNT and ERR_CNT SHALL saturate at all-ones and never wrap; ERR_CNT addition SHALL clamp at saturation.
REQ-025 Bytes received in HUNT or SYNC SHALL never change RECV_CNT, ERR_CNT or ERR_BYTE.
REQ-026 CLR=1 SHALL zero RECV_CNT and ERR_CNT on the next edge; the state, LFSR and run counter SHALL be unaffected.
REQ-027 When CLR=1 coincides with a valid locked byte, CLR SHALL win for the counters (the byte is not counted), while lock tracking and ERR_BYTE SHALL proceed normally.
REQ-028 DIN_VALID=0 SHALL hold all state and counters; ERR_BYTE SHALL be 0 on such cycles.

Reset
REQ-029 RSTX=0 SHALL immediately force: state=HUNT, LFSR=0, match_cnt=0, run counter=0, LOCKED=0, RECV_CNT=0, ERR_CNT=0, ERR_BYTE=0.
REQ-030 Reset asserted mid-lock SHALL discard alignment; after release, lock SHALL require a full HUNT/SYNC sequence again.

Verification
REQ-031 Clean PRBS7 stream, DIN_VALID always 1, defaults -> LOCKED rises after the 1 seed byte plus 16 matching bytes; 100 further bytes -> RECV_CNT=100, ERR_CNT=0.
REQ-032 While locked, flip 3 bits in one byte -> ERR_BYTE pulses once, ERR_CNT=3, LOCKED stays 1.
REQ-033 While locked, corrupt 4 consecutive bytes (1 bit each) -> ERR_CNT=4, LOCKED falls after the 4th byte; a clean stream then relocks after 17 bytes.
REQ-034 Constant 0x00 input -> state stays HUNT, LOCKED=0, counters stay 0.
REQ-035 CLR=1 on the same cycle as an errored locked byte -> RECV_CNT=0, ERR_CNT=0 the next cycle, ERR_BYTE=1.
REQ-036 Force ERR_CNT near saturation (32'hFFFF_FFFD), then inject a byte with 8 bit errors -> ERR_CNT=32'hFFFF_FFFF and stays there; DIN_VALID gaps during locked traffic -> no count changes in the gap cycles.
